// File: rtl/rl_desc_qm.sv
// Per-application descriptor queue manager sharing one memory.
// Each accepted descriptor also emits one scheduling token.
module rl_desc_qm #(
  parameter int APP_ID_WIDTH = 2,
  parameter int DESC_WIDTH   = 128,
  parameter int QUEUE_DEPTH  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DESC_WIDTH-1:0]   s_desc,
  input  logic [APP_ID_WIDTH-1:0] s_desc_app_id,
  input  logic [APP_ID_WIDTH-1:0] s_desc_prio,
  input  logic                    s_desc_valid,
  output logic                    s_desc_ready,
  input  logic                    qm_packet_desc_req,
  input  logic [APP_ID_WIDTH-1:0] qm_packet_desc_app_id,
  output logic [DESC_WIDTH-1:0]   qm_packet_desc,
  output logic                    qm_packet_desc_valid,
  output logic                    m_pifo_valid,
  output logic [APP_ID_WIDTH-1:0] m_pifo_prio,
  output logic [APP_ID_WIDTH-1:0] m_pifo_data,
  input  logic                    m_pifo_ready,
  output logic [2**APP_ID_WIDTH-1:0] m_app_nonempty,
  output logic [31:0]             underflow_count
);

  localparam int NA = 2**APP_ID_WIDTH;
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int PW = QW + 1;
  localparam int AW = APP_ID_WIDTH + QW;

  logic [PW-1:0] wr_ptr_q [NA];
  logic [PW-1:0] wr_ptr_d [NA];
  logic [PW-1:0] rd_ptr_q [NA];
  logic [PW-1:0] rd_ptr_d [NA];

  logic [DESC_WIDTH-1:0] mem_q [2**AW];
  logic [DESC_WIDTH-1:0] rd_data_q;
  logic                  rd_vld_q;
  logic [31:0]           uf_q;

  logic                    pv_q;
  logic [APP_ID_WIDTH-1:0] tok_prio_q;
  logic [APP_ID_WIDTH-1:0] tok_app_q;

  logic [NA-1:0] empty;
  logic [NA-1:0] full;
  logic          enq_ok;
  logic          deq_ok;
  logic          deq_uf;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;

  always_comb begin
    for (int a = 0; a < NA; a++) begin
      empty[a] = wr_ptr_q[a] == rd_ptr_q[a];
      full[a]  = (wr_ptr_q[a][PW-1] != rd_ptr_q[a][PW-1]) &&
                 (wr_ptr_q[a][QW-1:0] == rd_ptr_q[a][QW-1:0]);
    end
  end

  assign s_desc_ready = !full[s_desc_app_id] && (!pv_q || m_pifo_ready);

  assign enq_ok = s_desc_valid && s_desc_ready && !rst;
  assign deq_ok = qm_packet_desc_req && !empty[qm_packet_desc_app_id] && !rst;
  assign deq_uf = qm_packet_desc_req && empty[qm_packet_desc_app_id] && !rst;

  assign wr_addr = {s_desc_app_id, wr_ptr_q[s_desc_app_id][QW-1:0]};
  assign rd_addr = {qm_packet_desc_app_id,
                    rd_ptr_q[qm_packet_desc_app_id][QW-1:0]};

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (enq_ok)
      wr_ptr_d[s_desc_app_id] = wr_ptr_q[s_desc_app_id] + PW'(1);
    if (deq_ok)
      rd_ptr_d[qm_packet_desc_app_id] =
        rd_ptr_q[qm_packet_desc_app_id] + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int a = 0; a < NA; a++) begin
        wr_ptr_q[a] <= '0;
        rd_ptr_q[a] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok)
      mem_q[wr_addr] <= s_desc;
  end

  // Read data holds its last value; only the strobe is reset.
  always_ff @(posedge clk) begin
    if (deq_ok)
      rd_data_q <= mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld_q <= 1'b0;
      uf_q     <= '0;
    end else begin
      rd_vld_q <= deq_ok;
      if (deq_uf && !(&uf_q))
        uf_q <= uf_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pv_q       <= 1'b0;
      tok_prio_q <= '0;
      tok_app_q  <= '0;
    end else if (enq_ok) begin
      pv_q       <= 1'b1;
      tok_prio_q <= s_desc_prio;
      tok_app_q  <= s_desc_app_id;
    end else if (m_pifo_ready) begin
      pv_q       <= 1'b0;
      tok_prio_q <= '0;
      tok_app_q  <= '0;
    end
  end

  // A read in flight when reset arrives is dropped.
  assign qm_packet_desc_valid = rd_vld_q && !rst;
  assign qm_packet_desc       = rd_data_q;
  assign m_pifo_valid         = pv_q;
  assign m_pifo_prio          = tok_prio_q;
  assign m_pifo_data          = tok_app_q;
  assign m_app_nonempty       = ~empty;
  assign underflow_count      = uf_q;

endmodule

// File: tb/tb_rl_desc_qm.sv
// Scoreboard bench for rl_desc_qm.
// Reference queues per app plus token and read-data queues.
module tb_rl_desc_qm;

  localparam int AW = 2;
  localparam int DW = 128;
  localparam int QD = 16;
  localparam int NA = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] s_desc;
  logic [AW-1:0] s_desc_app_id;
  logic [AW-1:0] s_desc_prio;
  logic          s_desc_valid;
  logic          s_desc_ready;
  logic          qm_packet_desc_req;
  logic [AW-1:0] qm_packet_desc_app_id;
  logic [DW-1:0] qm_packet_desc;
  logic          qm_packet_desc_valid;
  logic          m_pifo_valid;
  logic [AW-1:0] m_pifo_prio;
  logic [AW-1:0] m_pifo_data;
  logic          m_pifo_ready;
  logic [NA-1:0] m_app_nonempty;
  logic [31:0]   underflow_count;

  rl_desc_qm #(
    .APP_ID_WIDTH(AW),
    .DESC_WIDTH(DW),
    .QUEUE_DEPTH(QD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s_desc(s_desc),
    .s_desc_app_id(s_desc_app_id),
    .s_desc_prio(s_desc_prio),
    .s_desc_valid(s_desc_valid),
    .s_desc_ready(s_desc_ready),
    .qm_packet_desc_req(qm_packet_desc_req),
    .qm_packet_desc_app_id(qm_packet_desc_app_id),
    .qm_packet_desc(qm_packet_desc),
    .qm_packet_desc_valid(qm_packet_desc_valid),
    .m_pifo_valid(m_pifo_valid),
    .m_pifo_prio(m_pifo_prio),
    .m_pifo_data(m_pifo_data),
    .m_pifo_ready(m_pifo_ready),
    .m_app_nonempty(m_app_nonempty),
    .underflow_count(underflow_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] mq [NA][$];
  logic [2*AW-1:0] tokq [$];
  logic [DW-1:0] rdq [$];
  logic [31:0] uf_m = '0;

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drv(bit v, int app, int pr, logic [DW-1:0] d,
                     bit rq, int qa);
    s_desc_valid          = v;
    s_desc_app_id         = AW'(app);
    s_desc_prio           = AW'(pr);
    s_desc                = d;
    qm_packet_desc_req    = rq;
    qm_packet_desc_app_id = AW'(qa);
  endtask

  task automatic flush();
    for (int a = 0; a < NA; a++) mq[a].delete();
    tokq.delete();
    rdq.delete();
    uf_m = '0;
  endtask

  function automatic logic [NA-1:0] ne_model();
    logic [NA-1:0] r;
    r = '0;
    for (int a = 0; a < NA; a++) r[a] = mq[a].size() != 0;
    return r;
  endfunction

  // Inputs are already driven; evaluate one cycle against the model.
  task automatic step();
    bit exp_pv;
    bit exp_rdy;
    #1;
    if (rst) begin
      flush();
    end else begin
      exp_pv = tokq.size() != 0;
      chk("pifo_v", m_pifo_valid, exp_pv);
      if (exp_pv)
        chk("token", {m_pifo_prio, m_pifo_data}, tokq[0]);
      exp_rdy = (mq[s_desc_app_id].size() < QD) &&
                (!exp_pv || m_pifo_ready);
      chk("s_rdy", s_desc_ready, exp_rdy);
      if (exp_pv && m_pifo_ready) void'(tokq.pop_front());
      if (qm_packet_desc_req) begin
        if (mq[qm_packet_desc_app_id].size() != 0)
          rdq.push_back(mq[qm_packet_desc_app_id].pop_front());
        else if (uf_m != 32'hFFFF_FFFF)
          uf_m++;
      end
      if (s_desc_valid && exp_rdy) begin
        mq[s_desc_app_id].push_back(s_desc);
        tokq.push_back({s_desc_prio, s_desc_app_id});
      end
    end
    @(posedge clk);
    #1;
    chk("dq_v", qm_packet_desc_valid, rdq.size() != 0);
    if (qm_packet_desc_valid && rdq.size() != 0)
      chk("dq_d", qm_packet_desc, rdq.pop_front());
    rdq.delete();
    chk("nonempty", m_app_nonempty, ne_model());
    chk("uflow", underflow_count, uf_m);
  endtask

  initial begin
    rst = 1'b1;
    m_pifo_ready = 1'b1;
    drv(0, 0, 0, '0, 0, 0);
    step();
    step();
    chk("rdy_rst", s_desc_ready, 1'b1);
    rst = 1'b0;
    step();

    // single enqueue then dequeue, token once
    drv(1, 2, 1, 128'hA1, 0, 0);
    step();
    drv(0, 0, 0, '0, 1, 2);
    step();
    drv(0, 0, 0, '0, 0, 0);
    step();
    step();

    // fill app 0, 17th refused
    for (int i = 0; i < 17; i++) begin
      drv(1, 0, i % 4, DW'(128'h100 + i), 0, 0);
      step();
    end
    chk("full_ne", m_app_nonempty, 4'b0001);
    for (int i = 0; i < 16; i++) begin
      drv(0, 0, 0, '0, 1, 0);
      step();
    end

    // underflow and saturation
    drv(0, 0, 0, '0, 1, 3);
    step();
    drv(0, 0, 0, '0, 0, 0);
    step();
    force dut.uf_q = 32'hFFFF_FFFF;
    #1;
    release dut.uf_q;
    uf_m = 32'hFFFF_FFFF;
    drv(0, 0, 0, '0, 1, 3);
    step();
    drv(0, 0, 0, '0, 0, 0);
    step();

    // token backpressure
    m_pifo_ready = 1'b0;
    drv(1, 1, 3, 128'hD1, 0, 0);
    step();
    drv(1, 1, 2, 128'hD2, 0, 0);
    step();
    step();
    m_pifo_ready = 1'b1;
    step();
    drv(0, 0, 0, '0, 0, 0);
    step();

    // same-cycle enqueue/dequeue on app 1
    drv(0, 0, 0, '0, 1, 1);
    step();
    drv(1, 1, 1, 128'hD3, 1, 1);
    step();
    drv(0, 0, 0, '0, 1, 1);
    step();
    drv(0, 0, 0, '0, 0, 0);
    step();

    // random traffic
    for (int i = 0; i < 300; i++) begin
      m_pifo_ready = ($urandom % 4) != 0;
      drv($urandom % 2, $urandom % 4, $urandom % 4,
          {$urandom, $urandom, $urandom, $urandom},
          $urandom % 2, $urandom % 4);
      step();
    end
    drv(0, 0, 0, '0, 0, 0);
    m_pifo_ready = 1'b1;
    step();

    // reset one cycle after a dequeue request
    drv(1, 0, 0, 128'hEE, 0, 0);
    step();
    drv(0, 0, 0, '0, 1, 0);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drv(0, 0, 0, '0, 0, 0);
    #1;
    chk("rst_nov", qm_packet_desc_valid, 1'b0);
    flush();
    step();
    rst = 1'b0;
    step();
    chk("rst_ne", m_app_nonempty, 4'b0000);
    chk("rst_uf", underflow_count, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
